dmem_responder: RTL and testbench

Data-port responder for the pipelined RV32I core: it sits on the memory end of the MEM stage's data interface and services word-aligned read and write requests with byte enables. It holds a single 32-byte line buffer (valid/dirty/tag) backed by physical memory over a 64-bit, 4-beat burst port. Hits complete with one-cycle latency; misses write back a dirty line if needed, then fill. Hit and miss performance counters are exposed.

---
 rtl/dmem_types.sv | 12 +
 rtl/pmem_burst_ctrl.sv | 17 +
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_types.sv
// dmem_types: shared state, geometry and byte-merge helper for the data responder
package dmem_types;
  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} dmem_state_t;
  localparam int LINE_BEATS = 4;
  localparam int BEAT_W = 64;
  typedef logic [255:0] line_t;
  typedef logic [26:0] tag_t;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    merge_bytes = old;
    for (int i = 0; i < 4; i++) merge_bytes[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/pmem_burst_ctrl.sv
// pmem_burst_ctrl: beat counter and last-beat detect shared by write-back and fill bursts
module pmem_burst_ctrl
  import dmem_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       resp,
  output logic [1:0] beat,
  output logic       done
);
  assign done = active && resp && beat == 2'(LINE_BEATS - 1);
  // advance one beat per accepted pmem response, wrapping back to 0 after the last
  always_ff @(posedge clk)
    if (rst) beat <= '0;
    else if (active && resp) beat <= beat + 2'd1;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-line write-back buffer servicing the core data port over a 4-beat burst port
module dmem_responder
  import dmem_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  dmem_state_t state;
  line_t line, line_n;
  tag_t tag;
  logic valid, dirty, done, hit;
  logic [1:0] beat;
  logic [2:0] widx;
  logic [3:0][BEAT_W-1:0] beats;
  logic [7:0][31:0] words;
  logic unused_addr;
  assign unused_addr = ^mem_address[1:0];
  assign widx = mem_address[4:2];
  assign hit = valid && tag == mem_address[31:5];
  assign pmem_read = state == FILL;
  assign pmem_write = state == WB;
  assign pmem_wdata = pmem_write ? beats[beat] : '0;
  assign pmem_address = pmem_write ? {tag, 5'b0} : pmem_read ? {mem_address[31:5], 5'b0} : '0;
  pmem_burst_ctrl u_burst (
    .clk    (clk),
    .rst    (rst),
    .active (pmem_read || pmem_write),
    .resp   (pmem_resp),
    .beat   (beat),
    .done   (done)
  );
  // next line contents: incoming fill beat, then the byte-merged store word
  always_comb begin
    beats = line;
    if (pmem_read && pmem_resp) beats[beat] = pmem_rdata;
    words = beats;
    if (state == RESP && mem_write) words[widx] = merge_bytes(words[widx], mem_wdata, mem_byte_enable);
    line_n = words;
  end
  // request FSM with registered response, line metadata and performance counters
  always_ff @(posedge clk) begin
    line <= line_n;
    if (rst) begin
      state      <= IDLE;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      tag        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      mem_resp   <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      case (state)
        IDLE: if (mem_read || mem_write) begin
          if (hit) begin
            hit_count <= hit_count + 32'd1;
            state     <= RESP;
            mem_resp  <= 1'b1;
            mem_rdata <= mem_write ? '0 : words[widx];
          end else begin
            miss_count <= miss_count + 32'd1;
            state      <= dirty ? WB : FILL;
          end
        end
        WB: if (done) begin
          dirty <= 1'b0;
          state <= FILL;
        end
        FILL: if (done) begin
          valid     <= 1'b1;
          dirty     <= 1'b0;
          tag       <= mem_address[31:5];
          state     <= RESP;
          mem_resp  <= 1'b1;
          mem_rdata <= mem_write ? '0 : words[widx];
        end
        RESP: begin
          if (mem_write) dirty <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of hits, clean/dirty misses, gapped fills and reset abort
module tb_dmem_responder;
  logic clk = 1'b0, rst = 1'b1, mem_read = 1'b0, mem_write = 1'b0;
  logic [3:0] mem_byte_enable = '0;
  logic [31:0] mem_address = '0, mem_wdata = '0, mem_rdata, pmem_address, hit_count, miss_count;
  logic mem_resp, pmem_read, pmem_write;
  logic [63:0] pmem_wdata, pmem_rdata = '0;
  logic pmem_resp = 1'b0;
  int nvec = 0, nerr = 0;
  logic [63:0] pm [logic [31:0]];
  logic [1:0] tb_beat = '0;
  logic [2:0] wcnt = '0;
  logic gap_mode = 1'b0, overlap = 1'b0, addr_err = 1'b0;
  logic [31:0] burst_addr = '0, wb_addr = '0, fill_addr = '0, ba;
  logic [63:0] wb_data [4];
  int pm_cycles = 0, fill_beats = 0;
  logic [31:0] rd;
  int lat, p, fb;
  logic reached;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
  );

  // physical memory: unwritten beats read back as {addr ^ A5A5_0000, addr}
  always @(negedge clk) begin
    if (pmem_read === 1'b1 && pmem_write === 1'b1) overlap = 1'b1;
    if (rst || !(pmem_read || pmem_write)) begin
      tb_beat = '0;
      wcnt = '0;
      pmem_resp = 1'b0;
    end else begin
      pm_cycles++;
      if (wcnt != 0) begin
        pmem_resp = 1'b0;
        wcnt--;
      end else begin
        if (tb_beat == 0) begin
          burst_addr = pmem_address;
          if (pmem_write) wb_addr = pmem_address;
          else fill_addr = pmem_address;
        end else if (pmem_address !== burst_addr) addr_err = 1'b1;
        ba = pmem_address + {27'd0, tb_beat, 3'd0};
        if (pmem_write) begin
          pm[ba] = pmem_wdata;
          wb_data[tb_beat] = pmem_wdata;
        end else begin
          pmem_rdata = pm.exists(ba) ? pm[ba] : {ba ^ 32'hA5A5_0000, ba};
          fill_beats++;
        end
        pmem_resp = 1'b1;
        tb_beat++;
        wcnt = gap_mode ? {1'b0, tb_beat} : 3'd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] r, output int l);
    mem_write = we;
    mem_read = !we;
    mem_address = a;
    mem_byte_enable = be;
    mem_wdata = wd;
    l = 0;
    r = 'x;
    for (int i = 1; i <= 200 && l == 0; i++) begin
      @(posedge clk);
      #1;
      if (mem_resp) begin
        l = i;
        r = mem_rdata;
      end
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", 64'(mem_resp), 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_miss", 64'(miss_count), 64'd0);
    chk("rst_pmem_rw", 64'({pmem_read, pmem_write}), 64'd0);
    chk("rst_pmem_addr", 64'(pmem_address), 64'd0);
    rst = 1'b0;

    do_req(1'b0, 32'h0000_0044, 4'h0, 32'h0, rd, lat);
    chk("cold_rdata", 64'(rd), 64'hA5A5_0040);
    chk("cold_lat", 64'(lat), 64'd5);
    chk("cold_fill_addr", 64'(fill_addr), 64'h40);
    chk("cold_miss", 64'(miss_count), 64'd1);
    chk("cold_hits", 64'(hit_count), 64'd0);
    chk("resp_one_cycle", 64'(mem_resp), 64'd0);

    p = pm_cycles;
    do_req(1'b0, 32'h0000_0048, 4'h0, 32'h0, rd, lat);
    chk("hit_rdata", 64'(rd), 64'h0000_0048);
    chk("hit_lat", 64'(lat), 64'd1);
    chk("hit_no_pmem", 64'(pm_cycles), 64'(p));
    chk("hit_count1", 64'(hit_count), 64'd1);

    do_req(1'b1, 32'h0000_0044, 4'b0010, 32'h0000_AB00, rd, lat);
    chk("wr_rdata_zero", 64'(rd), 64'd0);
    chk("wr_lat", 64'(lat), 64'd1);
    do_req(1'b0, 32'h0000_0044, 4'h0, 32'h0, rd, lat);
    chk("merge_rdata", 64'(rd), 64'hA5A5_AB40);
    chk("hit_count3", 64'(hit_count), 64'd3);

    do_req(1'b0, 32'h0000_1040, 4'h0, 32'h0, rd, lat);
    chk("dirty_lat", 64'(lat), 64'd9);
    chk("wb_addr", 64'(wb_addr), 64'h40);
    chk("wb_beat0", wb_data[0], 64'hA5A5_AB40_0000_0040);
    chk("dirty_fill_addr", 64'(fill_addr), 64'h1040);
    chk("dirty_rdata", 64'(rd), 64'h0000_1040);
    chk("dirty_miss", 64'(miss_count), 64'd2);

    gap_mode = 1'b1;
    do_req(1'b0, 32'h0000_2054, 4'h0, 32'h0, rd, lat);
    gap_mode = 1'b0;
    chk("gap_rdata", 64'(rd), 64'hA5A5_2050);
    chk("gap_lat", 64'(lat), 64'd11);
    chk("gap_miss", 64'(miss_count), 64'd3);

    mem_read = 1'b1;
    mem_address = 32'h0000_3000;
    fb = fill_beats;
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(posedge clk);
      #1;
      reached = fill_beats >= fb + 2;
    end
    chk("rst_wait", 64'(reached), 64'd1);
    rst = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_pmem_read", 64'(pmem_read), 64'd0);
    chk("abort_hits", 64'(hit_count), 64'd0);
    chk("abort_miss", 64'(miss_count), 64'd0);
    rst = 1'b0;

    do_req(1'b0, 32'h0000_3000, 4'h0, 32'h0, rd, lat);
    chk("reissue_rdata", 64'(rd), 64'h0000_3000);
    chk("reissue_lat", 64'(lat), 64'd5);
    chk("reissue_miss", 64'(miss_count), 64'd1);

    do_req(1'b0, 32'h0000_0044, 4'h0, 32'h0, rd, lat);
    chk("wb_persist_rdata", 64'(rd), 64'hA5A5_AB40);
    chk("wb_persist_miss", 64'(miss_count), 64'd2);
    chk("no_overlap", 64'(overlap), 64'd0);
    chk("addr_stable", 64'(addr_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
